// File: rtl/mux_2way_32_if.sv
// mux_2way_32_if: bundles the data, select and result signals of mux_2way_32.
//   master modport : drives en, a, b, sel; observes out, out_valid, sel_q
//   slave modport  : the mux itself (inverse directions)
// Optional: MUX_2WAY_32_PARITY_EN adds out_parity (slave -> master).
interface mux_2way_32_if #(
   parameter int WIDTH = 32
);
   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             sel_q;
`ifdef MUX_2WAY_32_PARITY_EN
   logic             out_parity;

   modport master (
      output en, a, b, sel,
      input  out, out_valid, sel_q, out_parity
   );

   modport slave (
      input  en, a, b, sel,
      output out, out_valid, sel_q, out_parity
   );
`else
   modport master (
      output en, a, b, sel,
      input  out, out_valid, sel_q
   );

   modport slave (
      input  en, a, b, sel,
      output out, out_valid, sel_q
   );
`endif
endinterface

// File: rtl/mux_2way_32.sv
// mux_2way_32: registered 2-way mux with load enable.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears out, sel_q, out_valid (and parity)
//   bus   : mux_2way_32_if.slave
//             en        load enable
//             a, b      data inputs (sel=0 -> a, sel=1 -> b)
//             out       registered mux result, 1-cycle latency
//             out_valid high for the single cycle after a load
//             sel_q     sel captured alongside out
//             out_parity XOR of out (only with MUX_2WAY_32_PARITY_EN defined)
// All outputs come straight from flops; no combinational input-to-output path.
module mux_2way_32 #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   mux_2way_32_if.slave  bus
);

   logic [WIDTH-1:0] out_d,       out_q;
   logic             sel_cap_d,   sel_cap_q;
   logic             out_valid_d, out_valid_q;
`ifdef MUX_2WAY_32_PARITY_EN
   logic             parity_d,    parity_q;
`endif

   always_comb begin
      out_d       = out_q;
      sel_cap_d   = sel_cap_q;
      out_valid_d = 1'b0;
`ifdef MUX_2WAY_32_PARITY_EN
      parity_d    = parity_q;
`endif
      if (bus.en) begin
         out_d       = bus.sel ? bus.b : bus.a;
         sel_cap_d   = bus.sel;
         out_valid_d = 1'b1;
`ifdef MUX_2WAY_32_PARITY_EN
         // Parity of the value being loaded, so it lines up with out.
         parity_d    = ^(bus.sel ? bus.b : bus.a);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         sel_cap_q   <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef MUX_2WAY_32_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         out_q       <= out_d;
         sel_cap_q   <= sel_cap_d;
         out_valid_q <= out_valid_d;
`ifdef MUX_2WAY_32_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign bus.out       = out_q;
   assign bus.sel_q     = sel_cap_q;
   assign bus.out_valid = out_valid_q;
`ifdef MUX_2WAY_32_PARITY_EN
   assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_2way_32.sv
// tb_mux_2way_32: self-checking bench for mux_2way_32 with directed and
// randomized stimulus against a cycle-level reference model.
module tb_mux_2way_32;

   localparam int WIDTH = 32;

   logic clk;
   logic reset;

   mux_2way_32_if #(.WIDTH(WIDTH)) bus ();

   mux_2way_32 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: what the outputs must show after the most recent edge.
   logic [WIDTH-1:0] exp_out;
   logic             exp_sel;
   logic             exp_valid;
   logic             exp_par;
   bit               primed = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: garbage inputs first (must not reach outputs), then the real
   // values that the next rising edge samples.
   task automatic step(input logic r, input logic e, input logic s,
                       input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      reset   = 1'($urandom);
      bus.en  = 1'($urandom);
      bus.sel = 1'($urandom);
      bus.a   = $urandom;
      bus.b   = $urandom;
      #2;
      if (primed) chk("no_comb_path", 64'(bus.out), 64'(exp_out));
      reset   = r;
      bus.en  = e;
      bus.sel = s;
      bus.a   = va;
      bus.b   = vb;
      @(posedge clk);
      if (r) begin
         exp_out   = '0;
         exp_sel   = 1'b0;
         exp_valid = 1'b0;
         exp_par   = 1'b0;
         primed    = 1'b1;
      end else if (e) begin
         exp_out   = s ? vb : va;
         exp_sel   = s;
         exp_valid = 1'b1;
         exp_par   = 1'($countones(exp_out) % 2);
      end else begin
         exp_valid = 1'b0;
      end
      #1;
      chk("out",       64'(bus.out),       64'(exp_out));
      chk("sel_q",     64'(bus.sel_q),     64'(exp_sel));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
`ifdef MUX_2WAY_32_PARITY_EN
      chk("out_parity", 64'(bus.out_parity), 64'(exp_par));
`endif
   endtask

   initial begin
      logic [WIDTH-1:0] ext [3];
      logic [WIDTH-1:0] v;
      reset   = 1'b0;
      bus.en  = 1'b0;
      bus.sel = 1'b0;
      bus.a   = '0;
      bus.b   = '0;
      exp_out = '0; exp_sel = 1'b0; exp_valid = 1'b0; exp_par = 1'b0;

      // Reset for 2 cycles with en high: reset must win.
      step(1'b1, 1'b1, 1'b0, 32'd5, 32'd9);
      step(1'b1, 1'b1, 1'b1, 32'd5, 32'd9);
      chk("reset_out_const", 64'(bus.out), 64'd0);
      // Idle after reset: reset values hold until the first load.
      step(1'b0, 1'b0, 1'b1, 32'd11, 32'd12);
      step(1'b0, 1'b0, 1'b0, 32'd13, 32'd14);

      // Select a, then select b with all-ones (parity 0).
      step(1'b0, 1'b1, 1'b0, 32'd7, 32'd3);
      chk("sel_a_out", 64'(bus.out), 64'd7);
      step(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFF);
      chk("sel_b_out", 64'(bus.out), 64'hFFFF_FFFF);

      // Sweep: a counts 0..15, sel 0,1,0,1 per value, en held high.
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 4; j++)
            step(1'b0, 1'b1, 1'(j % 2), WIDTH'(i), $urandom);

      // Hold: load 42 then three en=0 cycles with changing inputs.
      step(1'b0, 1'b1, 1'b0, 32'd42, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
         chk("hold_out_42", 64'(bus.out), 64'd42);
      end

      // Mid-stream reset coinciding with a load of 0x8000_0000.
      step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
      step(1'b1, 1'b1, 1'b1, 32'd0, 32'h8000_0000);
      chk("midrst_out_zero", 64'(bus.out), 64'd0);
      step(1'b0, 1'b1, 1'b1, 32'd0, 32'h8000_0000);
      chk("resume_out", 64'(bus.out), 64'h8000_0000);

      // Equal inputs and extreme values on either side.
      ext[0] = '0; ext[1] = '1; ext[2] = 32'h8000_0000;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0, ext[k], ext[k]);
         step(1'b0, 1'b1, 1'b1, ext[k], ext[k]);
         step(1'b0, 1'b1, 1'b0, ext[k], ~ext[k]);
         step(1'b0, 1'b1, 1'b1, ~ext[k], ext[k]);
      end

      // Randomized traffic: mostly enabled, occasional reset.
      for (int n = 0; n < 300; n++) begin
         v = $urandom;
         step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom), v, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
